// File: rtl/zap_bp_ram_ctrl.sv
// Write-side controller for the fetch-stage 2-bit branch-state RAM.
// Runs an init sweep after reset or flush, then writes ALU-resolved updates.
module zap_bp_ram_ctrl #(
  parameter int unsigned BP_ENTRIES = 1024,
  parameter logic [1:0]  INIT_STATE = 2'b01,
  localparam int unsigned AW = $clog2(BP_ENTRIES)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_stall,
  input  logic          i_clear_from_alu,
  input  logic          i_confirm_from_alu,
  input  logic [31:0]   i_pc_from_alu,
  input  logic [1:0]    i_taken,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [1:0]    o_wr_data,
  output logic          o_busy,
  output logic [7:0]    o_drop_cnt
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(BP_ENTRIES - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [1:0]    wr_data_d;
  logic          busy_d;
  logic [7:0]    drop_d;
  logic          upd;
  logic [1:0]    nxt;

  assign upd = !i_stall && (i_clear_from_alu || i_confirm_from_alu);

  // Saturating counter update; clear (mispredict) wins over confirm.
  always_comb begin
    nxt = i_taken;
    if (i_clear_from_alu) begin
      unique case (i_taken)
        2'b00:   nxt = 2'b01;
        2'b01:   nxt = 2'b10;
        2'b10:   nxt = 2'b01;
        default: nxt = 2'b10;
      endcase
    end else begin
      unique case (i_taken)
        2'b00:   nxt = 2'b00;
        2'b01:   nxt = 2'b00;
        2'b10:   nxt = 2'b11;
        default: nxt = 2'b11;
      endcase
    end
  end

  // Next state, sweep index, write port and drop counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = o_wr_addr;
    wr_data_d = o_wr_data;
    busy_d    = (state_q == INIT);
    drop_d    = o_drop_cnt;

    unique case (state_q)
      INIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = INIT_STATE;
        if (cnt_q == LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      RUN: begin
        if (upd && !i_flush) begin
          wr_en_d   = 1'b1;
          wr_addr_d = i_pc_from_alu[AW:1];
          wr_data_d = nxt;
        end
      end
      default: state_d = INIT;
    endcase

    if (i_flush) begin
      state_d = INIT;
      cnt_d   = '0;
    end

    if (upd && (i_flush || state_q == INIT) && o_drop_cnt != 8'hff) begin
      drop_d = o_drop_cnt + 8'd1;
    end
  end

  // Registered state and outputs with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= 2'b00;
      o_busy     <= 1'b1;
      o_drop_cnt <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_wr_en    <= wr_en_d;
      o_wr_addr  <= wr_addr_d;
      o_wr_data  <= wr_data_d;
      o_busy     <= busy_d;
      o_drop_cnt <= drop_d;
    end
  end

endmodule
